ccff_chain_loader: RTL and testbench

//  Sequencer for the configuration-chain (ccff_head -> ccff_tail) of a switch/connection block.
//  - Accepts config words over a valid/ready stream and serialises them onto ccff_head.
//  - Emits a per-cycle shift enable so the chain DFFs advance only when a valid bit is presented.
//  - Sits between the bitstream source and the tile chain; one instance drives one chain.

---
 rtl/ccff_chain_loader.sv | 179 +++++++++++++++++
 tb/tb_ccff_chain_loader.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: takes config words over a valid/ready stream and shifts
// them MSB first into one ccff_head -> ccff_tail configuration chain.
// Optional feature macro: CCFF_READBACK_EN. When defined, the loaded bits are
// CRC'd, the chain is recirculated once through the tail, and error reports a
// mismatch between the two CRCs. When undefined, error is tied low.
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 32,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = 6
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              shift_en,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int BL_W = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] CHAIN_LEN_C = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] LAST_C      = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W:0]   WORD_C      = (CNT_W + 1)'(WORD_W);
    localparam logic [BL_W-1:0]  WORD_BL     = BL_W'(WORD_W);

`ifdef CCFF_READBACK_EN
    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, VERIFY = 2'd2, DONE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DONE = 2'd3} state_t;
`endif

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  bitCnt_q, bitCnt_d;
    logic [BL_W-1:0]   bitsLeft_q, bitsLeft_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;

    logic              loadShift;
    logic [CNT_W:0]    remainingW;
    logic [CNT_W:0]    bitsLeftW;
    logic [CNT_W:0]    roomW;
    logic [BL_W-1:0]   loadLen;

`ifdef CCFF_READBACK_EN
    logic [15:0]       crcLd_q, crcLd_d;
    logic [15:0]       crcRb_q, crcRb_d;
    logic              error_q, error_d;

    // One MSB-first serial step of CRC-16-CCITT (poly 0x1021).
    function automatic logic [15:0] crcStep(input logic [15:0] crc, input logic bitIn);
        logic fb;
        fb = crc[15] ^ bitIn;
        return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    assign error = error_q;
`else
    logic tail_unused;
    assign tail_unused = ccff_tail;
    assign error       = 1'b0;
`endif

    // A word is accepted only if the chain still has room beyond the bits already
    // buffered; the final word is truncated so surplus low-order bits never shift.
    assign loadShift  = (bitsLeft_q != '0);
    assign remainingW = {1'b0, CHAIN_LEN_C - bitCnt_q};
    assign bitsLeftW  = (CNT_W + 1)'(bitsLeft_q);
    assign roomW      = remainingW - (CNT_W + 1)'(loadShift);
    assign loadLen    = (roomW > WORD_C) ? WORD_BL : BL_W'(roomW);

    // State register and datapath registers; reset aborts any load immediately.
    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            state_q    <= IDLE;
            bitCnt_q   <= '0;
            bitsLeft_q <= '0;
            shreg_q    <= '0;
`ifdef CCFF_READBACK_EN
            crcLd_q    <= 16'hFFFF;
            crcRb_q    <= 16'hFFFF;
            error_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            bitCnt_q   <= bitCnt_d;
            bitsLeft_q <= bitsLeft_d;
            shreg_q    <= shreg_d;
`ifdef CCFF_READBACK_EN
            crcLd_q    <= crcLd_d;
            crcRb_q    <= crcRb_d;
            error_q    <= error_d;
`endif
        end
    end

    // Next-state and output decode: serialise, refill bubble-free, then finish.
    always_comb begin
        state_d    = state_q;
        bitCnt_d   = bitCnt_q;
        bitsLeft_d = bitsLeft_q;
        shreg_d    = shreg_q;
`ifdef CCFF_READBACK_EN
        crcLd_d    = crcLd_q;
        crcRb_d    = crcRb_q;
        error_d    = error_q;
`endif
        cfg_ready  = 1'b0;
        ccff_head  = 1'b0;
        shift_en   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    bitCnt_d   = '0;
                    bitsLeft_d = '0;
                    shreg_d    = '0;
`ifdef CCFF_READBACK_EN
                    crcLd_d    = 16'hFFFF;
                    crcRb_d    = 16'hFFFF;
                    error_d    = 1'b0;
`endif
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                busy      = 1'b1;
                shift_en  = loadShift;
                ccff_head = loadShift & shreg_q[WORD_W-1];
                cfg_ready = (bitsLeft_q <= BL_W'(1)) && (bitCnt_q < CHAIN_LEN_C) &&
                            (remainingW > bitsLeftW);
                if (loadShift) begin
                    shreg_d    = {shreg_q[WORD_W-2:0], 1'b0};
                    bitsLeft_d = bitsLeft_q - BL_W'(1);
                    bitCnt_d   = bitCnt_q + CNT_W'(1);
`ifdef CCFF_READBACK_EN
                    crcLd_d    = crcStep(crcLd_q, shreg_q[WORD_W-1]);
`endif
                    if (bitCnt_q == LAST_C) begin
`ifdef CCFF_READBACK_EN
                        state_d  = VERIFY;
                        bitCnt_d = '0;
`else
                        state_d  = DONE;
`endif
                    end
                end
                if (cfg_ready && cfg_valid) begin
                    shreg_d    = cfg_data;
                    bitsLeft_d = loadLen;
                end
            end
`ifdef CCFF_READBACK_EN
            VERIFY: begin
                busy      = 1'b1;
                shift_en  = 1'b1;
                ccff_head = ccff_tail;
                crcRb_d   = crcStep(crcRb_q, ccff_tail);
                bitCnt_d  = bitCnt_q + CNT_W'(1);
                if (bitCnt_q == LAST_C) begin
                    error_d = (crcRb_d != crcLd_q);
                    state_d = DONE;
                end
            end
`endif
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: a 32-bit and a 30-bit chain share one stream,
// each chain is modelled as a plain shift register clocked by shift_en.
module tb_ccff_chain_loader;

`ifdef CCFF_READBACK_EN
    localparam int RB = 1;
`else
    localparam int RB = 0;
`endif
    localparam int NUM_VEC = 5 + RB;

    logic        progClk = 1'b0;
    logic        pReset;
    logic        start;
    logic [7:0]  cfgData;
    logic        cfgValid;
    logic        ready32, head32, shift32, busy32, done32, error32, tail32;
    logic        ready30, head30, shift30, busy30, done30, error30, tail30;
    logic [31:0] chain32  = '0;
    logic [29:0] chain30  = '0;
    logic [31:0] flipMask = '0;

    always #5 progClk = ~progClk;

    // Chain models; flipMask lets a single DFF of the 32-bit chain be corrupted.
    always @(posedge progClk) begin
        if (shift32) chain32 <= {chain32[30:0], head32} ^ flipMask;
        else         chain32 <= chain32 ^ flipMask;
        if (shift30) chain30 <= {chain30[28:0], head30};
    end

    assign tail32 = chain32[31];
    assign tail30 = chain30[29];

    ccff_chain_loader #(.CHAIN_LEN(32), .WORD_W(8), .CNT_W(6)) dut32 (
        .prog_clk(progClk), .pReset(pReset), .start(start), .cfg_data(cfgData),
        .cfg_valid(cfgValid), .cfg_ready(ready32), .ccff_head(head32), .ccff_tail(tail32),
        .shift_en(shift32), .busy(busy32), .done(done32), .error(error32));

    ccff_chain_loader #(.CHAIN_LEN(30), .WORD_W(8), .CNT_W(6)) dut30 (
        .prog_clk(progClk), .pReset(pReset), .start(start), .cfg_data(cfgData),
        .cfg_valid(cfgValid), .cfg_ready(ready30), .ccff_head(head30), .ccff_tail(tail30),
        .shift_en(shift30), .busy(busy30), .done(done30), .error(error30));

    typedef struct {
        logic [31:0] words;
        int          resetAtBit;
        int          stallLen;
        int          startBusyAt;
        bit          validInIdle;
        bit          startInDone30;
        int          flipAt;
        logic [31:0] expChain32;
        logic [29:0] expChain30;
        int          expDone32;
        int          expDone30;
        bit          expErr32;
    } vecT;

    vecT vecs [NUM_VEC];
    int  total = 0;
    int  bad   = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int vi, input vecT v);
        int done32At = -1;
        int done30At = -1;
        int doneCnt32 = 0;
        int shifts32 = 0;
        int shifts30 = 0;
        int acc32 = 0;
        int acc30 = 0;
        int headCnt = 0;
        int zeroShift = 0;
        int withheldZero = 0;
        int idx = 0;
        bit firstShift = 0;
        bit withhold;
        logic [31:0] headSeq = '0;

        cfgValid = 1'b0;
        if (v.validInIdle) begin
            cfgData  = 8'hEE;
            cfgValid = 1'b1;
            repeat (3) begin
                @(negedge progClk);
                checkOutput($sformatf("v%0d idleValid", vi),
                            {58'd0, ready32, ready30, busy32, busy30, shift32, shift30}, 64'd0);
            end
            cfgValid = 1'b0;
        end
        @(negedge progClk);
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (cyc > 0) @(negedge progClk);
            if (v.resetAtBit > 0 && headCnt == v.resetAtBit) begin
                start    = 1'b0;
                cfgValid = 1'b0;
                pReset   = 1'b1;
                #1;
                checkOutput($sformatf("v%0d midReset32", vi),
                            {58'd0, ready32, shift32, head32, busy32, done32, error32}, 64'd0);
                checkOutput($sformatf("v%0d midReset30", vi),
                            {58'd0, ready30, shift30, head30, busy30, done30, error30}, 64'd0);
                @(negedge progClk);
                pReset = 1'b0;
                return;
            end
            if (shift32) begin
                shifts32++;
                firstShift = 1'b1;
                if (headCnt < 32) begin
                    headSeq = {headSeq[30:0], head32};
                    headCnt++;
                end
            end else if (busy32 && firstShift && headCnt < 32) begin
                zeroShift++;
            end
            if (shift30) shifts30++;
            if (done32) begin
                doneCnt32++;
                if (done32At < 0) done32At = cyc;
                checkOutput($sformatf("v%0d busyInDone", vi), {63'd0, busy32}, 64'd0);
            end
            if (done30 && done30At < 0) done30At = cyc;
            if (cyc == 1) begin
                checkOutput($sformatf("v%0d busyAfterStart", vi), {63'd0, busy32}, 64'd1);
                checkOutput($sformatf("v%0d errClearedByStart", vi), {63'd0, error32}, 64'd0);
            end

            start = (cyc == 0) || (v.startBusyAt != 0 && cyc == v.startBusyAt) ||
                    (v.startInDone30 && done30 === 1'b1);
            flipMask = (v.flipAt != 0 && cyc == v.flipAt) ? 32'h0010_0000 : 32'h0;

            if (idx < 4) begin
                withhold = (idx == 2) && (v.stallLen > 0) &&
                           (!ready32 || shift32 || withheldZero < v.stallLen - 1);
                if (withhold) begin
                    cfgValid = 1'b0;
                    if (ready32 && !shift32) withheldZero++;
                end else begin
                    cfgValid = 1'b1;
                    cfgData  = v.words[31-8*idx -: 8];
                end
            end else begin
                cfgValid = 1'b0;
            end
            if (cfgValid && ready30) acc30++;
            if (cfgValid && ready32) begin
                acc32++;
                idx++;
            end

            if (done32At >= 0 && done30At >= 0 &&
                cyc > ((done32At > done30At) ? done32At : done30At)) break;
        end
        start    = 1'b0;
        cfgValid = 1'b0;
        flipMask = '0;

        checkOutput($sformatf("v%0d doneLatency32", vi), 64'(done32At), 64'(v.expDone32));
        checkOutput($sformatf("v%0d doneLatency30", vi), 64'(done30At), 64'(v.expDone30));
        checkOutput($sformatf("v%0d donePulseLen", vi), 64'(doneCnt32), 64'd1);
        checkOutput($sformatf("v%0d shiftCount32", vi), 64'(shifts32), 64'(32 * (1 + RB)));
        checkOutput($sformatf("v%0d shiftCount30", vi), 64'(shifts30), 64'(30 * (1 + RB)));
        checkOutput($sformatf("v%0d headSeq32", vi), {32'd0, headSeq}, {32'd0, v.words});
        checkOutput($sformatf("v%0d stallCycles", vi), 64'(zeroShift), 64'(v.stallLen));
        checkOutput($sformatf("v%0d accepted32", vi), 64'(acc32), 64'd4);
        checkOutput($sformatf("v%0d accepted30", vi), 64'(acc30), 64'd4);
        checkOutput($sformatf("v%0d chain32", vi), {32'd0, chain32}, {32'd0, v.expChain32});
        checkOutput($sformatf("v%0d chain30", vi), {34'd0, chain30}, {34'd0, v.expChain30});

        repeat (2) @(negedge progClk);
        checkOutput($sformatf("v%0d idleAfter", vi),
                    {58'd0, busy32, busy30, ready32, ready30, done32, error30}, 64'd0);
        checkOutput($sformatf("v%0d errorHeld", vi), {63'd0, error32}, {63'd0, v.expErr32});
    endtask

    initial begin
        int k;
        pReset   = 1'b1;
        start    = 1'b0;
        cfgValid = 1'b0;
        cfgData  = 8'h00;

        k = 0;
        vecs[k++] = '{words: 32'hA53CFF01, resetAtBit: 13, stallLen: 0, startBusyAt: 0,
                      validInIdle: 0, startInDone30: 0, flipAt: 0, expChain32: 32'h0,
                      expChain30: 30'h0, expDone32: 0, expDone30: 0, expErr32: 0};
        vecs[k++] = '{words: 32'hA53CFF01, resetAtBit: 0, stallLen: 0, startBusyAt: 0,
                      validInIdle: 0, startInDone30: 0, flipAt: 0, expChain32: 32'hA53CFF01,
                      expChain30: {24'hA53CFF, 6'b000000}, expDone32: 34 + 32 * RB,
                      expDone30: 32 + 30 * RB, expErr32: 0};
        vecs[k++] = '{words: 32'hA53CFF01, resetAtBit: 0, stallLen: 3, startBusyAt: 0,
                      validInIdle: 0, startInDone30: 0, flipAt: 0, expChain32: 32'hA53CFF01,
                      expChain30: {24'hA53CFF, 6'b000000}, expDone32: 37 + 32 * RB,
                      expDone30: 35 + 30 * RB, expErr32: 0};
        vecs[k++] = '{words: 32'h12345678, resetAtBit: 0, stallLen: 0, startBusyAt: 10,
                      validInIdle: 1, startInDone30: 1, flipAt: 0, expChain32: 32'h12345678,
                      expChain30: {24'h123456, 6'b011110}, expDone32: 34 + 32 * RB,
                      expDone30: 32 + 30 * RB, expErr32: 0};
`ifdef CCFF_READBACK_EN
        vecs[k++] = '{words: 32'hA53CFF01, resetAtBit: 0, stallLen: 0, startBusyAt: 0,
                      validInIdle: 0, startInDone30: 0, flipAt: 36,
                      expChain32: 32'hA53CFF01 ^ 32'h0002_0000,
                      expChain30: {24'hA53CFF, 6'b000000}, expDone32: 66, expDone30: 62,
                      expErr32: 1};
`endif
        vecs[k++] = '{words: 32'hFF00F00F, resetAtBit: 0, stallLen: 1, startBusyAt: 0,
                      validInIdle: 0, startInDone30: 0, flipAt: 0, expChain32: 32'hFF00F00F,
                      expChain30: {24'hFF00F0, 6'b000011}, expDone32: 35 + 32 * RB,
                      expDone30: 33 + 30 * RB, expErr32: 0};

        repeat (2) @(negedge progClk);
        checkOutput("resetState32",
                    {58'd0, ready32, shift32, head32, busy32, done32, error32}, 64'd0);
        pReset = 1'b0;
        @(negedge progClk);
        checkOutput("afterReset",
                    {58'd0, ready32, shift32, busy32, ready30, shift30, busy30}, 64'd0);

        for (int i = 0; i < NUM_VEC; i++) begin
            $display("[TB] vector %0d words=0x%08h", i, vecs[i].words);
            applyStimulus(i, vecs[i]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
